rom_fetch_queue: RTL and testbench
==================================

// Module: rom_fetch_queue
// PURPOSE
//   Instruction fetch unit with prefetch FIFO. Issues sequential ROM reads under a req/grant
//   handshake, absorbs fixed ROM latency with multiple reads in flight, and buffers fetched words.
//   Flushes and redirects on jump. Sits between the ROM arbiter and the decode stage.
// PARAMETERS
//   DATA_W     14  ROM word / command width
//   ADDR_W     12  ROM address width
//   DEPTH      4   prefetch FIFO entries; power of two, >=2
//   READ_LAT   2   cycles from accepted request to rom_data valid; 1..7
//   RESET_ADDR 0   IP value after reset
// PORTS
//   clk            in   1                     clock, rising edge
//   reset          in   1                     asynchronous, active-low reset
//   pause          in   1                     1 = issue no new ROM requests
//   rom_rd         out  1                     ROM read request
//   rom_rd_garant  in   1                     grant; request accepted when rom_rd && rom_rd_garant
//   rom_addr       out  ADDR_W                address of current request; 0 when rom_rd=0
//   rom_data       in   DATA_W                read data, valid exactly READ_LAT cycles after acceptance
//   jmp_valid      in   1                     one-cycle redirect strobe
//   jmp_addr       in   ADDR_W                redirect target, sampled when jmp_valid=1
//   cmd_valid      out  1                     FIFO head valid
//   cmd_ready      in   1                     consumer takes head when cmd_valid && cmd_ready
//   cmd_data       out  DATA_W                head command word
//   cmd_addr       out  ADDR_W                ROM address of head word
//   fifo_count     out  $clog2(DEPTH+1)       entries held
// BEHAVIOUR
//   Reset (reset=0, async): IP=RESET_ADDR; FIFO empty; in-flight pipe cleared; all outputs 0.
//   Credit: inflight + fifo_count < DEPTH. rom_rd=1 iff !pause && !jmp_valid && credit;
//     rom_rd is combinational from registered state + pause/jmp_valid. rom_addr=IP while rom_rd=1.
//   Accept: rom_rd && rom_rd_garant -> IP<=IP+1 (wraps 2^ADDR_W-1 -> 0); {valid,IP} enters
//     a READ_LAT-stage shift pipe. No grant: rom_rd stays high, IP held, rom_addr stable.
//   Capture: when pipe output valid, rom_data and tagged addr are pushed into FIFO that cycle.
//     Credit rule guarantees a push never finds FIFO full; overflow is a design error.
//   Pop: cmd_valid && cmd_ready removes head; cmd_data/cmd_addr combinational from head.
//     Push+pop same cycle: count unchanged. Pop when empty: ignored.
//   Jump (jmp_valid=1): FIFO flushed, all pipe valid bits cleared (late data discarded),
//     IP<=jmp_addr, rom_rd=0 that cycle; first request from jmp_addr next cycle.
//     A pop completed in the jump cycle counts; any push in the jump cycle is dropped.
//     Jump is honoured while paused; IP updated, issue waits for pause=0.
//   Pause: blocks only issue; in-flight data still captured; pops continue.
//   State: IDLE (no credit or paused), REQ (rom_rd high, awaiting grant); jump forces IDLE for
//     one cycle. Counters: inflight 0..DEPTH, fifo_count 0..DEPTH, wr/rd ptrs mod DEPTH.
//   Reset mid-operation: everything cleared immediately, no outputs glitch beyond reset values.
// TESTING
//   1 Grant tied 1, cmd_ready=1, READ_LAT=2: after reset cmd_addr 0,1,2,... one per cycle from cycle 3.
//   2 cmd_ready=0: exactly DEPTH=4 requests accepted (addr 0..3), rom_rd then 0, fifo_count=4.
//   3 Grant held 0 for 5 cycles: rom_rd=1, rom_addr constant, IP unchanged; resumes on grant.
//   4 jmp_valid with jmp_addr=0x100 while 2 in flight: stale data dropped, next cmd_addr=0x100.
//   5 IP=0xFFF, accept: next rom_addr=0x000; pause=1 with reads in flight -> all still delivered.
//   6 Assert reset mid-burst: outputs 0 at once, first request after release is RESET_ADDR.

Source files
------------

// File: rtl/rom_fetch_queue.sv
// rtl/rom_fetch_queue.sv - instruction fetch unit with ROM request pipe and prefetch FIFO
module rom_fetch_queue #(
  parameter int DATA_W     = 14,
  parameter int ADDR_W     = 12,
  parameter int DEPTH      = 4,
  parameter int READ_LAT   = 2,
  parameter int RESET_ADDR = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pause,
  output logic                         rom_rd,
  input  logic                         rom_rd_garant,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [DATA_W-1:0]            rom_data,
  input  logic                         jmp_valid,
  input  logic [ADDR_W-1:0]            jmp_addr,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [DATA_W-1:0]            cmd_data,
  output logic [ADDR_W-1:0]            cmd_addr,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] ip;
  logic [READ_LAT-1:0] pipe_vld;
  logic [ADDR_W-1:0] pipe_addr [READ_LAT];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW:0] occupied;
  logic credit;
  logic accept;
  logic push;
  logic pop;

  // Every in-flight read has a FIFO slot reserved, so a capture can never overflow.
  assign occupied   = {1'b0, inflight} + {1'b0, count};
  assign credit     = occupied < (CW+1)'(DEPTH);
  // Gating with reset keeps rom_rd low for the whole time reset is held.
  assign rom_rd     = reset && !pause && !jmp_valid && credit;
  assign rom_addr   = rom_rd ? ip : '0;
  assign accept     = rom_rd && rom_rd_garant;
  // Data landing in a jump cycle belongs to the old stream and is discarded.
  assign push       = pipe_vld[READ_LAT-1] && !jmp_valid;
  assign cmd_valid  = count != '0;
  assign pop        = cmd_valid && cmd_ready;
  assign cmd_data   = cmd_valid ? mem_data[rd_ptr] : '0;
  assign cmd_addr   = cmd_valid ? mem_addr[rd_ptr] : '0;
  assign fifo_count = count;

  // Instruction pointer, address-tagged latency pipe and in-flight counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ip       <= ADDR_W'(RESET_ADDR);
      pipe_vld <= '0;
      inflight <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_addr[i] <= '0;
    end else if (jmp_valid) begin
      ip       <= jmp_addr;
      pipe_vld <= '0;
      inflight <= '0;
    end else begin
      if (accept) ip <= ip + ADDR_W'(1);
      pipe_vld[0]  <= accept;
      pipe_addr[0] <= ip;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
      inflight <= inflight + CW'(accept) - CW'(pipe_vld[READ_LAT-1]);
    end
  end

  // FIFO pointers and occupancy; a jump empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (jmp_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage: returned word plus the address it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= rom_data;
      mem_addr[wr_ptr] <= pipe_addr[READ_LAT-1];
    end
  end

endmodule

// File: tb/tb_rom_fetch_queue.sv
// tb/tb_rom_fetch_queue.sv - randomized self-checking bench for rom_fetch_queue
module tb_rom_fetch_queue;
  localparam int DATA_W   = 14;
  localparam int ADDR_W   = 12;
  localparam int DEPTH    = 4;
  localparam int READ_LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pause = 1'b0;
  logic rom_rd;
  logic rom_rd_garant = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic jmp_valid = 1'b0;
  logic [ADDR_W-1:0] jmp_addr = '0;
  logic cmd_valid;
  logic cmd_ready = 1'b0;
  logic [DATA_W-1:0] cmd_data;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0] fifo_count;

  rom_fetch_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT), .RESET_ADDR(0)) dut (
    .clk(clk), .reset(reset), .pause(pause), .rom_rd(rom_rd), .rom_rd_garant(rom_rd_garant),
    .rom_addr(rom_addr), .rom_data(rom_data), .jmp_valid(jmp_valid), .jmp_addr(jmp_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_addr(cmd_addr),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int due; } rd_t;

  int nerr = 0;
  int nchk = 0;
  int cyc = 0;
  int m_ip = 0;
  rd_t m_fl[$];
  int m_fifo[$];
  rd_t rom_q[$];

  logic s_rd, s_cv;
  logic [ADDR_W-1:0] s_ra, s_ca;
  logic [2:0] s_cnt;

  function automatic logic [DATA_W-1:0] romf(int a);
    return DATA_W'((a * 37) ^ 'h2a5);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle; entered and left at a falling edge with the caller's inputs applied.
  task automatic step();
    logic e_rd, e_cv, acc;
    int e_ra, e_ca, e_cd;
    rd_t r;
    if (rom_q.size() > 0 && rom_q[0].due == cyc) begin
      r = rom_q.pop_front();
      rom_data = romf(r.addr);
    end else begin
      rom_data = DATA_W'($urandom);
    end
    e_rd = !pause && !jmp_valid && (m_fl.size() + m_fifo.size() < DEPTH);
    e_ra = e_rd ? m_ip : 0;
    e_cv = m_fifo.size() > 0;
    e_ca = e_cv ? m_fifo[0] : 0;
    e_cd = e_cv ? int'(romf(e_ca)) : 0;
    #1;
    chk("rom_rd", int'(rom_rd), int'(e_rd));
    chk("rom_addr", int'(rom_addr), e_ra);
    chk("cmd_valid", int'(cmd_valid), int'(e_cv));
    chk("cmd_addr", int'(cmd_addr), e_ca);
    chk("cmd_data", int'(cmd_data), e_cd);
    chk("fifo_count", int'(fifo_count), m_fifo.size());
    s_rd = rom_rd; s_ra = rom_addr; s_cv = cmd_valid; s_ca = cmd_addr; s_cnt = fifo_count;
    @(posedge clk);
    acc = e_rd && rom_rd_garant;
    if (acc) rom_q.push_back('{m_ip, cyc + READ_LAT});
    if (jmp_valid) begin
      m_fl.delete();
      m_fifo.delete();
      m_ip = int'(jmp_addr);
    end else begin
      if (e_cv && cmd_ready) void'(m_fifo.pop_front());
      if (m_fl.size() > 0 && m_fl[0].due == cyc) begin
        r = m_fl.pop_front();
        m_fifo.push_back(r.addr);
      end
      if (acc) begin
        m_fl.push_back('{m_ip, cyc + READ_LAT});
        m_ip = (m_ip + 1) % (1 << ADDR_W);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Asserts reset at a falling edge (possibly mid-burst), checks outputs at once, releases later.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("reset_outputs", int'({rom_rd, rom_addr, cmd_valid, cmd_data, cmd_addr, fifo_count}), 0);
    m_fl.delete();
    m_fifo.delete();
    rom_q.delete();
    m_ip = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_in(input logic p, input logic g, input logic rdy);
    pause = p; rom_rd_garant = g; cmd_ready = rdy; jmp_valid = 1'b0;
  endtask

  initial begin
    int acc_cnt;
    bit found;
    @(negedge clk);
    do_reset();

    // Streaming: one command per cycle starting three cycles after release.
    set_in(0, 1, 1);
    for (int k = 0; k < 10; k++) begin
      step();
      if (k >= 3) chk("stream_addr", int'({s_cv, s_ca}), int'({1'b1, 12'(k - 3)}));
    end

    // Consumer stalled: exactly DEPTH reads issued.
    do_reset();
    set_in(0, 1, 0);
    acc_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (s_rd) acc_cnt++;
    end
    chk("stall_accepts", acc_cnt, 4);
    chk("stall_count", int'(s_cnt), 4);
    chk("stall_rom_rd", int'(s_rd), 0);
    chk("stall_head", int'(s_ca), 0);

    // Grant withheld: request held steady, then advances on grant.
    do_reset();
    set_in(0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("nogrant_req", int'({s_rd, s_ra}), int'({1'b1, 12'h000}));
    end
    rom_rd_garant = 1'b1;
    step();
    chk("grant_addr0", int'(s_ra), 0);
    step();
    chk("grant_addr1", int'(s_ra), 1);

    // Jump with reads in flight: stale words dropped.
    step();
    jmp_valid = 1'b1; jmp_addr = 12'h100;
    step();
    chk("jmp_no_rd", int'(s_rd), 0);
    jmp_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (s_cv) found = 1;
    end
    chk("jmp_first_addr", found ? int'(s_ca) : -1, 'h100);

    // Address wrap, then pause with reads still outstanding.
    set_in(0, 1, 0);
    jmp_valid = 1'b1; jmp_addr = 12'hFFF;
    step();
    jmp_valid = 1'b0;
    step();
    chk("wrap_fff", int'(s_ra), 'hFFF);
    step();
    chk("wrap_000", int'(s_ra), 'h000);
    pause = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("pause_delivered", int'(s_cnt), 2);
    chk("pause_head", int'(s_ca), 'hFFF);

    // Reset in the middle of a burst.
    set_in(0, 1, 1);
    repeat (4) step();
    do_reset();
    step();
    chk("post_reset_req", int'({s_rd, s_ra}), int'({1'b1, 12'h000}));

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      pause = ($urandom_range(99) < 20);
      rom_rd_garant = ($urandom_range(99) < 70);
      cmd_ready = ($urandom_range(99) < 60);
      jmp_valid = ($urandom_range(99) < 3);
      jmp_addr = ($urandom_range(3) == 0) ? 12'(12'hFFE + $urandom_range(1)) : 12'($urandom);
      if ($urandom_range(999) < 2) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
